ase_emul_pcie_ss_axis_demux: RTL and testbench

// Downstream counterpart of the PCIe SS AXI-S N:1 mux in the ASE emulation path: splits one
// AXI-S TLP stream into NUM_CH streams. Routing is decoded from a header field on the SOP beat.
// The route is held for the whole packet. Each output has a 2-entry registered skid buffer,
// so every output is register-driven and the block sustains full throughput.
//

---
 rtl/ase_emul_pcie_ss_axis_demux_if.sv | 38 +++
 rtl/ase_emul_pcie_ss_axis_demux.sv | 112 +++++++++++
 tb/tb_ase_emul_pcie_ss_axis_demux.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/ase_emul_pcie_ss_axis_demux_if.sv
// rtl/ase_emul_pcie_ss_axis_demux_if.sv - AXI-S 1:N demux stream bundle (one input stream, NUM_CH packed outputs)
interface ase_emul_pcie_ss_axis_demux_if #(
    parameter int NUM_CH      = 2,
    parameter int TDATA_WIDTH = 512,
    parameter int TUSER_WIDTH = 10
);
    localparam int TKEEP_WIDTH = TDATA_WIDTH / 8;

    logic                            s_tvalid;
    logic                            s_tready;
    logic [TDATA_WIDTH-1:0]          s_tdata;
    logic [TKEEP_WIDTH-1:0]          s_tkeep;
    logic                            s_tlast;
    logic [TUSER_WIDTH-1:0]          s_tuser_vendor;

    logic [NUM_CH-1:0]               m_tvalid;
    logic [NUM_CH-1:0]               m_tready;
    logic [NUM_CH*TDATA_WIDTH-1:0]   m_tdata;
    logic [NUM_CH*TKEEP_WIDTH-1:0]   m_tkeep;
    logic [NUM_CH-1:0]               m_tlast;
    logic [NUM_CH*TUSER_WIDTH-1:0]   m_tuser_vendor;

    // Demux side: consumes the input stream, produces the output streams
    modport slave (
        input  s_tvalid, s_tdata, s_tkeep, s_tlast, s_tuser_vendor,
        output s_tready,
        output m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser_vendor,
        input  m_tready
    );

    // Environment side: drives the input stream, sinks the output streams
    modport master (
        output s_tvalid, s_tdata, s_tkeep, s_tlast, s_tuser_vendor,
        input  s_tready,
        input  m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser_vendor,
        output m_tready
    );
endinterface

// File: rtl/ase_emul_pcie_ss_axis_demux.sv
// rtl/ase_emul_pcie_ss_axis_demux.sv - AXI-S TLP 1:N demux with SOP route decode and per-channel 2-entry skid buffers
module ase_emul_pcie_ss_axis_demux #(
    parameter int NUM_CH      = 2,
    parameter int TDATA_WIDTH = 512,
    parameter int TUSER_WIDTH = 10,
    parameter int SEL_LSB     = 160,
    parameter int DEFAULT_CH  = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    ase_emul_pcie_ss_axis_demux_if.slave   bus,
    output logic                           bad_route
);
    localparam int TKEEP_WIDTH = TDATA_WIDTH / 8;
    localparam int SEL_WIDTH   = $clog2(NUM_CH);
    localparam int BEAT_WIDTH  = TDATA_WIDTH + TKEEP_WIDTH + 1 + TUSER_WIDTH;

    // One extra bit so NUM_CH itself is representable when it is a power of two
    localparam logic [SEL_WIDTH:0]   NUM_CH_W    = (SEL_WIDTH + 1)'(NUM_CH);
    localparam logic [SEL_WIDTH-1:0] DEFAULT_SEL = SEL_WIDTH'(DEFAULT_CH);

    logic                  in_pkt;
    logic [SEL_WIDTH-1:0]  held_dest;
    logic [SEL_WIDTH-1:0]  route;
    logic                  route_bad;
    logic                  sop;
    logic [SEL_WIDTH-1:0]  dest;
    logic                  dest_full;
    logic                  hs;
    logic [NUM_CH-1:0]     full;
    logic [BEAT_WIDTH-1:0] in_beat;

    // Route decode: only the SOP beat's header field matters, later beats follow held_dest
    always_comb begin
        route     = bus.s_tdata[SEL_LSB +: SEL_WIDTH];
        route_bad = ({1'b0, route} >= NUM_CH_W);
        sop       = ~in_pkt;
        dest      = held_dest;
        if (sop) begin
            dest = route_bad ? DEFAULT_SEL : route;
        end
        dest_full = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (dest == SEL_WIDTH'(c)) begin
                dest_full = full[c];
            end
        end
    end

    // Backpressure looks only at the destination buffer occupancy, never at m_tready
    assign bus.s_tready = ~reset & ~dest_full;
    assign hs           = bus.s_tvalid & bus.s_tready;
    assign in_beat      = {bus.s_tdata, bus.s_tkeep, bus.s_tlast, bus.s_tuser_vendor};

    // Packet framing state, held route and sticky bad-route flag
    always_ff @(posedge clk) begin
        if (reset) begin
            in_pkt    <= 1'b0;
            held_dest <= DEFAULT_SEL;
            bad_route <= 1'b0;
        end else if (hs) begin
            in_pkt <= ~bus.s_tlast;
            if (sop) begin
                held_dest <= dest;
                if (route_bad) begin
                    bad_route <= 1'b1;
                end
            end
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic [1:0]            cnt;
        logic [BEAT_WIDTH-1:0] head;
        logic [BEAT_WIDTH-1:0] skid;
        logic                  push;
        logic                  pop;

        assign push     = hs & (dest == SEL_WIDTH'(ch));
        assign pop      = (cnt != 2'd0) & bus.m_tready[ch];
        assign full[ch] = (cnt == 2'd2);

        // Occupancy: push and pop together leave the count unchanged
        always_ff @(posedge clk) begin
            if (reset) begin
                cnt <= 2'd0;
            end else if (push && !pop) begin
                cnt <= cnt + 2'd1;
            end else if (pop && !push) begin
                cnt <= cnt - 2'd1;
            end
        end

        // Data path: head feeds the output, skid catches a beat while head is stalled
        always_ff @(posedge clk) begin
            if (push && ((cnt == 2'd0) || ((cnt == 2'd1) && pop))) begin
                head <= in_beat;
            end else if (pop && (cnt == 2'd2)) begin
                head <= skid;
            end
            if (push && (cnt == 2'd1) && !pop) begin
                skid <= in_beat;
            end
        end

        assign bus.m_tvalid[ch] = (cnt != 2'd0);
        assign {bus.m_tdata[ch*TDATA_WIDTH +: TDATA_WIDTH],
                bus.m_tkeep[ch*TKEEP_WIDTH +: TKEEP_WIDTH],
                bus.m_tlast[ch],
                bus.m_tuser_vendor[ch*TUSER_WIDTH +: TUSER_WIDTH]} = head;
    end
endmodule

// File: tb/tb_ase_emul_pcie_ss_axis_demux.sv
// tb/tb_ase_emul_pcie_ss_axis_demux.sv - scoreboard bench for the AXI-S 1:N demux
`timescale 1ns/1ps
module tb_ase_emul_pcie_ss_axis_demux;
    localparam int NCH = 3;
    localparam int DW  = 256;
    localparam int KW  = DW / 8;
    localparam int UW  = 10;

    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
        logic [UW-1:0] u;
        int            acc;
        bit            chk_lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic bad_route;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q [NCH][$];

    ase_emul_pcie_ss_axis_demux_if #(.NUM_CH(NCH), .TDATA_WIDTH(DW), .TUSER_WIDTH(UW)) bus ();

    ase_emul_pcie_ss_axis_demux #(
        .NUM_CH(NCH), .TDATA_WIDTH(DW), .TUSER_WIDTH(UW), .SEL_LSB(160), .DEFAULT_CH(0)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus), .bad_route(bad_route)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic logic [DW-1:0] mk_data(input int pkt, input int beat, input logic [1:0] field);
        logic [DW-1:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = {pkt[15:0], beat[15:0]} ^ (32'h1111_1111 * i);
        v[161:160] = field;
        return v;
    endfunction

    // Monitor: every accepted output beat is popped from its channel queue and compared
    always @(negedge clk) begin
        if (!reset) begin
            for (int c = 0; c < NCH; c++) begin
                if (bus.m_tvalid[c] && bus.m_tready[c]) begin
                    checks++;
                    if (exp_q[c].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_beat ch%0d actual_data=%h required=none", c, bus.m_tdata[c*DW +: DW]);
                    end else begin
                        exp_t e;
                        e = exp_q[c].pop_front();
                        if (bus.m_tdata[c*DW +: DW] !== e.d || bus.m_tkeep[c*KW +: KW] !== e.k ||
                            bus.m_tlast[c] !== e.l || bus.m_tuser_vendor[c*UW +: UW] !== e.u) begin
                            errors++;
                            $display("FAIL beat ch%0d actual d=%h k=%h l=%b u=%h required d=%h k=%h l=%b u=%h", c,
                                     bus.m_tdata[c*DW +: DW], bus.m_tkeep[c*KW +: KW], bus.m_tlast[c],
                                     bus.m_tuser_vendor[c*UW +: UW], e.d, e.k, e.l, e.u);
                        end
                        if (e.chk_lat) begin
                            checks++;
                            if (cyc - e.acc != 1) begin
                                errors++;
                                $display("FAIL latency ch%0d actual=%0d required=1", c, cyc - e.acc);
                            end
                        end
                    end
                end
            end
        end
    end

    // Drives one beat until accepted; the expected beat is queued on the hand-chosen channel
    task automatic send(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l,
                        input logic [UW-1:0] u, input int ch, input bit chk_lat);
        int   t;
        exp_t e;
        bus.s_tvalid       = 1'b1;
        bus.s_tdata        = d;
        bus.s_tkeep        = k;
        bus.s_tlast        = l;
        bus.s_tuser_vendor = u;
        t = 0;
        forever begin
            @(negedge clk);
            if (bus.s_tready) begin
                e.d = d; e.k = k; e.l = l; e.u = u; e.acc = cyc; e.chk_lat = chk_lat;
                exp_q[ch].push_back(e);
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
            t++;
            if (t > 200) begin
                errors++;
                $display("FAIL accept_timeout ch%0d actual=stalled required=accepted", ch);
                break;
            end
        end
        bus.s_tvalid = 1'b0;
    endtask

    task automatic send_pkt(input int pkt, input int n, input logic [1:0] sop_field,
                            input logic [1:0] mid_field, input int ch, input bit chk_lat);
        for (int b = 0; b < n; b++) begin
            send(mk_data(pkt, b, (b == 0) ? sop_field : mid_field),
                 (b == n - 1) ? 32'h0000_FFFF : 32'hFFFF_FFFF,
                 (b == n - 1), UW'(pkt * 8 + b), ch, chk_lat);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset              = 1'b1;
        bus.s_tvalid       = 1'b0;
        bus.s_tdata        = '0;
        bus.s_tkeep        = '0;
        bus.s_tlast        = 1'b0;
        bus.s_tuser_vendor = '0;
        bus.m_tready       = 3'b111;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_tvalid", int'(bus.m_tvalid), 0);
        chk("rst_s_tready", int'(bus.s_tready), 0);
        chk("rst_bad_route", int'(bad_route), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // 3-beat packet to ch1, full rate, 1-cycle latency
        send_pkt(1, 3, 2'd1, 2'd1, 1, 1);
        idle(3);
        chk("t1_drained_m_tvalid", int'(bus.m_tvalid), 0);

        // Non-SOP route bits are ignored, including an out-of-range value
        send_pkt(2, 3, 2'd1, 2'd0, 1, 1);
        send_pkt(3, 3, 2'd1, 2'd3, 1, 1);
        send_pkt(4, 1, 2'd2, 2'd0, 2, 1);
        send_pkt(5, 2, 2'd0, 2'd2, 0, 1);
        idle(3);
        chk("t2_bad_route_clear", int'(bad_route), 0);

        // ch1 stalled mid-packet: buffer fills, input stalls, all beats delivered after release
        bus.m_tready = 3'b101;
        fork
            send_pkt(6, 4, 2'd1, 2'd1, 1, 0);
            begin
                repeat (3) @(negedge clk);
                chk("t3_s_tready_full", int'(bus.s_tready), 0);
                chk("t3_m_tvalid", int'(bus.m_tvalid), 2);
                @(posedge clk); #1;
                bus.m_tready = 3'b111;
            end
        join
        idle(4);

        // Head-of-line blocking behind a full ch0; ch1 still drains its own data
        bus.m_tready = 3'b000;
        send_pkt(7, 1, 2'd1, 2'd1, 1, 0);
        fork
            begin
                send_pkt(8, 3, 2'd0, 2'd0, 0, 0);
                send_pkt(9, 2, 2'd1, 2'd1, 1, 0);
            end
            begin
                repeat (4) @(negedge clk);
                chk("t4_s_tready_blocked", int'(bus.s_tready), 0);
                chk("t4_m_tvalid_both", int'(bus.m_tvalid), 3);
                @(posedge clk); #1;
                bus.m_tready = 3'b010;
                repeat (3) @(negedge clk);
                chk("t4_ch1_drained", int'(bus.m_tvalid), 1);
                chk("t4_still_blocked", int'(bus.s_tready), 0);
                @(posedge clk); #1;
                bus.m_tready = 3'b111;
            end
        join
        idle(4);

        // Out-of-range SOP route goes to the default channel and sets the sticky flag
        send_pkt(10, 2, 2'd3, 2'd1, 0, 1);
        idle(2);
        chk("t5_bad_route_set", int'(bad_route), 1);
        send_pkt(11, 1, 2'd1, 2'd1, 1, 1);
        idle(2);
        chk("t5_bad_route_sticky", int'(bad_route), 1);

        // Mid-packet reset with both buffers occupied
        bus.m_tready = 3'b000;
        send_pkt(12, 1, 2'd0, 2'd0, 0, 0);
        send(mk_data(13, 0, 2'd1), 32'hFFFF_FFFF, 1'b0, UW'(13 * 8), 1, 0);
        @(negedge clk);
        chk("t6_pre_m_tvalid", int'(bus.m_tvalid), 3);
        @(posedge clk); #1;
        reset              = 1'b1;
        bus.s_tvalid       = 1'b1;
        bus.s_tdata        = mk_data(14, 1, 2'd1);
        bus.s_tlast        = 1'b0;
        @(negedge clk);
        chk("t6_rst_s_tready", int'(bus.s_tready), 0);
        @(posedge clk);
        @(negedge clk);
        chk("t6_rst_m_tvalid", int'(bus.m_tvalid), 0);
        chk("t6_rst_bad_route", int'(bad_route), 0);
        for (int c = 0; c < NCH; c++) exp_q[c].delete();
        @(posedge clk); #1;
        reset        = 1'b0;
        bus.s_tvalid = 1'b0;
        bus.m_tready = 3'b111;
        send_pkt(15, 1, 2'd2, 2'd0, 2, 1);
        idle(4);

        for (int c = 0; c < NCH; c++) chk($sformatf("end_queue_ch%0d", c), exp_q[c].size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
